// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//
// Memory-side responder for a cache's 256-bit downward-facing port (dfp).
// One line read or line write is accepted at a time. It is carried out as a
// four-beat, 64-bit burst on the banked-memory (bmem) interface, and the cache
// is then answered with a single-cycle dfp_resp.
//
// Ports
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   dfp_addr      : line address from the cache (bits [4:0] ignored)
//   dfp_read      : level read request, held until dfp_resp
//   dfp_write     : level write request, held until dfp_resp (wins over read)
//   dfp_wdata     : line to write, valid while dfp_write
//   dfp_rdata     : assembled read line (holds last line, 0 after reset)
//   dfp_resp      : one-cycle completion pulse
//   bmem_addr     : line-aligned burst address while a request is active
//   bmem_read     : read burst request, held until bmem_ready
//   bmem_write    : write beat strobe, beat taken when bmem_ready
//   bmem_wdata    : current write beat
//   bmem_ready    : memory accepts the request/beat this cycle
//   bmem_raddr    : tag of returning read data (not used; one read in flight)
//   bmem_rdata    : read beat
//   bmem_rvalid   : read beat valid
//
// Every output is a flop. Output flops are loaded from the next-state values,
// so they line up with the state they describe without any input-to-output path.

module cacheline_adapter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdData,
        StResp
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [26:0]  line_q, line_d;     // line number, i.e. dfp_addr[31:5]
    logic [255:0] wbuf_q, wbuf_d;
    logic [255:0] rbuf_q, rbuf_d;

    logic         resp_q, resp_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [31:0]  baddr_q, baddr_d;
    logic [63:0]  bwdata_q, bwdata_d;

    // The returning-data tag and the in-line offset carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{bmem_raddr, dfp_addr[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;

        unique case (state_q)
            StIdle: begin
                if (dfp_write) begin
                    state_d = StWr;
                    line_d  = dfp_addr[31:5];
                    wbuf_d  = dfp_wdata;
                    cnt_d   = '0;
                end else if (dfp_read) begin
                    state_d = StRdReq;
                    line_d  = dfp_addr[31:5];
                    cnt_d   = '0;
                end
            end
            StWr: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StResp;
                    end
                end
            end
            StRdReq: begin
                if (bmem_ready) begin
                    state_d = StRdData;
                    cnt_d   = '0;
                end
            end
            StRdData: begin
                if (bmem_rvalid) begin
                    rbuf_d[{cnt_q, 6'b0} +: 64] = bmem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                // The cache still holds its request here; never re-accept it.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output flops follow the state being entered.
        resp_d   = (state_d == StResp);
        rd_d     = (state_d == StRdReq);
        wr_d     = (state_d == StWr);
        baddr_d  = (rd_d || wr_d) ? {line_d, 5'b0} : '0;
        bwdata_d = wr_d ? wbuf_d[{cnt_d, 6'b0} +: 64] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            line_q   <= '0;
            wbuf_q   <= '0;
            rbuf_q   <= '0;
            resp_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            wbuf_q   <= wbuf_d;
            rbuf_q   <= rbuf_d;
            resp_q   <= resp_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign dfp_rdata  = rbuf_q;
    assign dfp_resp   = resp_q;
    assign bmem_addr  = baddr_q;
    assign bmem_read  = rd_q;
    assign bmem_write = wr_q;
    assign bmem_wdata = bwdata_q;

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache's 256-bit downward-facing port (dfp). Accepts one line read or line write at a time from the cache. Converts it into a four-beat, 64-bit burst on the banked-memory (bmem) interface, then returns a single-cycle `dfp_resp`. It sits between each cache instance's dfp and the memory arbiter/bmem model, and holds exactly one transaction in flight.

## Interface
- Parameters: none (line = 256 bits, beat = 64 bits, 4 beats/line, fixed).
- `clk` in 1 — sole clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `dfp_addr` in 32 — line address from cache; bits [4:0] ignored.
- `dfp_read` in 1 — level request, held by cache until `dfp_resp`.
- `dfp_write` in 1 — level request, held by cache until `dfp_resp`.
- `dfp_wdata` in 256 — write line, valid while `dfp_write`.
- `dfp_rdata` out 256 — assembled read line, valid when `dfp_resp`.
- `dfp_resp` out 1 — one-cycle completion pulse.
- `bmem_addr` out 32 — burst address, `{dfp_addr[31:5],5'h00}`.
- `bmem_read` out 1 — read burst request.
- `bmem_write` out 1 — write beat strobe.
- `bmem_wdata` out 64 — current write beat.
- `bmem_ready` in 1 — memory accepts request/beat this cycle.
- `bmem_raddr` in 32 — address tag of returning read data (unused for data steering).
- `bmem_rdata` in 64 — read beat.
- `bmem_rvalid` in 1 — read beat valid.

## Operation
- State `IDLE`: outputs idle. Sample `dfp_write` first, then `dfp_read`; write has priority if both are high. On accept, latch the aligned address into `addr_r` and `dfp_wdata` into `wbuf`, clear beat counter `cnt` (2 bits). Next state is `WR` for a write and `RDREQ` for a read.
- `WR`: `bmem_write=1`, `bmem_addr=addr_r`, `bmem_wdata=wbuf[64*cnt +: 64]`. Beat transfers when `bmem_ready` is 1; `cnt` increments only then. Transfer at `cnt==3` goes to `RESP`.
- `RDREQ`: `bmem_read=1`, `bmem_addr=addr_r`. Hold until `bmem_ready`, then go to `RDDATA` with `cnt=0`.
- `RDDATA`: no bmem request. Each `bmem_rvalid` writes `bmem_rdata` into `rbuf[64*cnt +: 64]` and increments `cnt`. Gaps between beats are allowed. Beat at `cnt==3` goes to `RESP`.
- `RESP`: `dfp_resp=1` for exactly one cycle; `dfp_rdata=rbuf`. Next state is `IDLE` unconditionally. Requests seen during `RESP` are never accepted, because the cache's request is still asserted then.
- `dfp_rdata` is driven from `rbuf` at all times. It holds its last value outside `RESP` and is `0` after reset.
- `bmem_rvalid` outside `RDDATA` is ignored; `rbuf` is unchanged.
- `bmem_raddr` is not compared against `addr_r`; only one outstanding read is allowed.
- Reset mid-operation: state returns to `IDLE` immediately and asynchronously, with all registers cleared. Beats returning after reset are ignored.

## Timing
- Reset values: `dfp_resp=0`, `dfp_rdata=0`, `bmem_read=0`, `bmem_write=0`, `bmem_addr=0`, `bmem_wdata=0`.
- All outputs are decoded from registered state/buffers only. No input-to-output combinational path exists.
- Write, with `bmem_ready` held at 1 and request seen in cycle 0:
  - cycles 1–4 carry beats 0–3;
  - `dfp_resp` is high in cycle 5;
  - each low-`bmem_ready` cycle adds 1.
- Read, with request seen in cycle 0:
  - `bmem_read` is high in cycle 1 (if ready);
  - last beat arrives in cycle N;
  - `dfp_resp` is high in cycle N+1.
- Back-to-back: a request held in the cycle after `RESP` is accepted in that `IDLE` cycle. This gives a 1-cycle gap, which covers the cache's writeback-then-allocate sequence.
- `bmem_read` lasts exactly one accepted cycle per transaction.
- `bmem_write` is asserted for exactly 4 accepted beats per transaction.

## Test plan
- Read, ready=1:
  - stimulus: `dfp_read`, addr `0x0000_1234`; rvalid beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` in consecutive cycles;
  - required: `bmem_addr=0x0000_1220`, one `bmem_read` pulse, `dfp_rdata={44..,33..,22..,11..}`, single `dfp_resp` one cycle after beat 4.
- Write with backpressure:
  - stimulus: `dfp_write`, addr `0x8000_0040`, wdata beat k = `k+1` replicated; `bmem_ready` low on the 2nd beat cycle;
  - required: beats 1,2,3,4 in order, exactly 4 accepted strobes, `dfp_resp` in cycle 6.
- Writeback then allocate:
  - stimulus: write to `0x100` completes, then cache raises `dfp_read` at `0x200` in the cycle after resp;
  - required: read accepted that cycle, `bmem_addr=0x200`, no duplicate write.
- Gapped read:
  - stimulus: rvalid beats separated by 0, 3 and 1 idle cycles; spurious rvalid in `IDLE` beforehand;
  - required: correct line assembled, spurious beat ignored, `dfp_resp` once.
- Simultaneous requests:
  - stimulus: `dfp_read` and `dfp_write` both high in `IDLE`;
  - required: write burst executes first.
- Async reset:
  - stimulus: `rst_n` low after 2 write beats;
  - required: all outputs 0 immediately, state `IDLE`, no `dfp_resp`, next request starts at beat 0.
